mac_seq: RTL and testbench

- Sequential fixed-point multiply-accumulate (dot product) over a streamed vector pair.
- Sits directly upstream of add3b1 and produces one of its argument operands, e.g. the row·column term of a matrix element update.
- Accepts one (a, b) element pair per beat, accumulates at full precision, then rounds and clips to g.WIDTH.
- Presents one result per vector with a valid/ready handshake.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/mac_seq_if.sv | 13 +
 rtl/mac_seq_mul_reg.sv | 26 ++
 rtl/mac_seq.sv | 98 +++++++++
 tb/tb_mac_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, widths and round/clip helper for mac_seq (MAC_SEQ_SATURATE_EN selects clip vs wrap)
package mac_pkg;

  localparam int PKG_WIDTH = 32;
  localparam int PKG_SCALE = 16;
  localparam int PKG_GUARD = 8;
  localparam int ACC_W     = 2 * PKG_WIDTH + PKG_GUARD;

  typedef enum logic [1:0] {ACC, DRAIN, ROUND, OUT} state_t;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] r;
    logic                 ovf;
  } rc_t;

  // Round half up at the binary point, then clip or wrap to a width-bit result.
  function automatic rc_t round_clip(input logic signed [ACC_W-1:0] acc,
                                     input int scale, input int width);
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    rc_t res;
    one = 1;
    t   = {acc[ACC_W-1], acc};
    t   = t + (one <<< (scale - 1));
    t   = t >>> scale;
    hi  = (one <<< (width - 1)) - one;
    lo  = -(one <<< (width - 1));
    res.ovf = (t > hi) || (t < lo);
    res.r   = t[PKG_WIDTH-1:0];
`ifdef MAC_SEQ_SATURATE_EN
    if (t > hi) res.r = hi[PKG_WIDTH-1:0];
    else if (t < lo) res.r = lo[PKG_WIDTH-1:0];
`endif
    return res;
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - fixedp interface: clock, reset and fixed-point format shared by the datapath
interface fixedp
  import mac_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH,
  parameter int SCALE = PKG_SCALE
);
  logic clk;
  logic reset;

  modport master (output clk, reset);
  modport slave  (input clk, reset);
endinterface

// File: rtl/mac_seq_mul_reg.sv
// rtl/mac_seq_mul_reg.sv - registered signed multiplier with valid pass-through
module mul_reg
  import mac_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  output logic signed [2*WIDTH-1:0] p
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) p <= a * b;
    end
  end

endmodule

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - streamed fixed-point dot product with rounding, clip/wrap (MAC_SEQ_SATURATE_EN) and ovf flag
module mac_seq
  import mac_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH,
  parameter int SCALE = PKG_SCALE,
  parameter int GUARD = PKG_GUARD
) (
  fixedp.slave             g,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf
);

  localparam int AW = 2 * WIDTH + GUARD;
  localparam logic [GUARD:0] CNT_FULL = {1'b1, {GUARD{1'b0}}};
  localparam logic [GUARD:0] CNT_LAST = {1'b0, {GUARD{1'b1}}};
  localparam logic [GUARD:0] CNT_ONE  = {{GUARD{1'b0}}, 1'b1};

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic [GUARD:0]          count;
  logic                    len_err;
  logic                    accept;
  logic                    p_valid;
  logic signed [2*WIDTH-1:0] p;
  rc_t                     rc;

  assign accept = in_valid && in_ready;

  mul_reg #(.WIDTH(WIDTH)) u_mul (
    .clk       (g.clk),
    .reset     (g.reset),
    .in_valid  (accept),
    .a         (a),
    .b         (b),
    .out_valid (p_valid),
    .p         (p)
  );

  always_comb begin
    rc = round_clip(acc, SCALE, WIDTH);
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      f         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      count     <= '0;
      len_err   <= 1'b0;
    end else begin
      if (p_valid) acc <= acc + {{GUARD{p[2*WIDTH-1]}}, p};
      case (state)
        ACC: begin
          if (accept) begin
            if (count != CNT_FULL) count <= count + CNT_ONE;
            // 2^GUARD beats seen and this one is not the last: vector too long
            if (!in_last && count == CNT_LAST) len_err <= 1'b1;
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: state <= ROUND;
        ROUND: begin
          f         <= rc.r[WIDTH-1:0];
          ovf       <= rc.ovf | len_err;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
            count     <= '0;
            len_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed self-checking bench for mac_seq (expectations follow MAC_SEQ_SATURATE_EN)
module tb_mac_seq;

  fixedp #(.WIDTH(32), .SCALE(16)) g();

  logic        in_valid, in_ready, in_last, out_valid, out_ready, ovf;
  logic [31:0] a, b, f;
  int          n_cmp, n_err, lat;
  logic [31:0] va[$];
  logic [31:0] vb[$];
  logic [31:0] exp_ovf_f;

  mac_seq dut (
    .g         (g),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .ovf       (ovf)
  );

  initial begin
    g.clk = 1'b0;
    forever #5 g.clk = ~g.clk;
  end

  task automatic step();
    @(posedge g.clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed(input bit bubble);
    for (int i = 0; i < va.size(); i++) begin
      in_valid = 1'b1;
      a        = va[i];
      b        = vb[i];
      in_last  = (i == va.size() - 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (bubble && i != va.size() - 1) step();
    end
  endtask

  task automatic wait_out();
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic result(input string tag, input logic [31:0] ef, input logic eovf);
    chk({tag, "_busy"}, in_ready, 0);
    wait_out();
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_f"}, f, ef);
    chk({tag, "_ovf"}, ovf, eovf);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_vclr"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    in_valid = 0; in_last = 0; a = 0; b = 0; out_ready = 0;
    g.reset = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_f", f, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    g.reset = 1'b0;
    step();

    // 1.0*3.0 + 2.0*-1.0 + 0.5*4.0 = 3.0, with bubbles between beats
    va = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000};
    vb = '{32'h0003_0000, 32'hFFFF_0000, 32'h0004_0000};
    feed(1'b1);
    result("dot3", 32'h0003_0000, 1'b0);

    va = '{32'h0000_0001}; vb = '{32'h0000_8000};
    feed(1'b0);
    result("rnd_pos", 32'h0000_0001, 1'b0);

    va = '{32'hFFFF_FFFF}; vb = '{32'h0000_8000};
    feed(1'b0);
    result("rnd_neg", 32'h0000_0000, 1'b0);

`ifdef MAC_SEQ_SATURATE_EN
    exp_ovf_f = 32'h7FFF_FFFF;
`else
    exp_ovf_f = 32'hFFFC_0000;
`endif
    va = '{32'h7FFF_0000}; vb = '{32'h0004_0000};
    feed(1'b0);
    result("ovf", exp_ovf_f, 1'b1);

    // Backpressure: result held for 5 cycles, then next vector right after handshake
    va = '{32'h0001_0000}; vb = '{32'h0001_0000};
    feed(1'b0);
    wait_out();
    chk("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid, ovf, in_ready, f}, {1'b1, 1'b0, 1'b0, 32'h0001_0000});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rdy_next", in_ready, 1);
    va = '{32'h0002_0000}; vb = '{32'h0003_0000};
    feed(1'b0);
    result("bp_next", 32'h0006_0000, 1'b0);

    // Reset after 2 of 3 beats, product still in flight
    in_valid = 1'b1; a = 32'h0001_0000; b = 32'h0005_0000; in_last = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    g.reset = 1'b1;
    step();
    g.reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_f", f, 0);
    va = '{32'h0002_0000}; vb = '{32'h0002_0000};
    feed(1'b0);
    result("post_rst", 32'h0004_0000, 1'b0);

    // Exactly 2^GUARD beats is a legal vector
    va.delete(); vb.delete();
    for (int i = 0; i < 256; i++) begin
      va.push_back(32'h0001_0000);
      vb.push_back(32'h0001_0000);
    end
    feed(1'b0);
    result("len256", 32'h0100_0000, 1'b0);

    // 256 beats without last, then a last beat: length error, full sum kept
    va.push_back(32'h0001_0000);
    vb.push_back(32'h0001_0000);
    feed(1'b0);
    result("len257", 32'h0101_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
